// File: rtl/ecc_pkg.sv
// Shared SECDED definitions for the encoder and decoder stages: modes, status codes,
// per-mode widths, parity-check matrices and small decode helpers.
package ecc_pkg;

    localparam int CW_MAX   = 32;
    localparam int INFO_MAX = 26;
    localparam int P_MAX    = 6;

    typedef enum logic [1:0] {
        MODE_8_4     = 2'b00,
        MODE_16_11   = 2'b01,
        MODE_32_26   = 2'b10,
        MODE_INVALID = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        STATUS_CLEAN     = 2'b00,
        STATUS_CORRECTED = 2'b01,
        STATUS_UNCORR    = 2'b10,
        STATUS_INVALID   = 2'b11
    } status_e;

    localparam int INFO_W_1   = 4;
    localparam int PARITY_W_1 = 4;
    localparam int INFO_W_2   = 11;
    localparam int PARITY_W_2 = 5;
    localparam int INFO_W_3   = 26;
    localparam int PARITY_W_3 = 6;

    typedef logic [P_MAX-1:0][CW_MAX-1:0] hmat_t;

    // Info columns take successive non-power-of-two values, so they are distinct
    // and never collide with a check-bit (unit) column.
    function automatic hmat_t build_h(input int p, input int n);
        hmat_t h;
        int    v;
        h = '0;
        v = 3;
        for (int c = 0; c < n; c++) begin
            h[0][c] = 1'b1;
            if (c < p - 1) begin
                h[c + 1][c] = 1'b1;
            end else if (c >= p) begin
                if ((v & (v - 1)) == 0) v++;
                for (int r = 1; r < p; r++) h[r][c] = v[r - 1];
                v++;
            end
        end
        return h;
    endfunction

    localparam hmat_t H_MATRIX_1 = build_h(PARITY_W_1, INFO_W_1 + PARITY_W_1);
    localparam hmat_t H_MATRIX_2 = build_h(PARITY_W_2, INFO_W_2 + PARITY_W_2);
    localparam hmat_t H_MATRIX_3 = build_h(PARITY_W_3, INFO_W_3 + PARITY_W_3);

    function automatic hmat_t h_for_mode(input logic [1:0] m);
        case (m)
            MODE_16_11: return H_MATRIX_2;
            MODE_32_26: return H_MATRIX_3;
            default:    return H_MATRIX_1;
        endcase
    endfunction

    function automatic logic [CW_MAX-1:0] cw_mask(input logic [1:0] m);
        case (m)
            MODE_16_11: return 32'h0000_FFFF;
            MODE_32_26: return 32'hFFFF_FFFF;
            default:    return 32'h0000_00FF;
        endcase
    endfunction

    function automatic logic [INFO_MAX-1:0] info_of(input logic [CW_MAX-1:0] cw, input logic [1:0] m);
        case (m)
            MODE_8_4:   return INFO_MAX'(cw[7:4]);
            MODE_16_11: return INFO_MAX'(cw[15:5]);
            MODE_32_26: return cw[31:6];
            default:    return '0;
        endcase
    endfunction

    function automatic status_e classify(input logic [1:0] m, input logic [P_MAX-1:0] syn,
                                         input logic [CW_MAX-1:0] match);
        if (m == MODE_INVALID) return STATUS_INVALID;
        if (syn == '0)         return STATUS_CLEAN;
        if (|match)            return STATUS_CORRECTED;
        return STATUS_UNCORR;
    endfunction

    function automatic logic [4:0] onehot_idx(input logic [CW_MAX-1:0] oh);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < CW_MAX; i++) begin
            if (oh[i]) idx = idx | 5'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/ecc_dec_stage_if.sv
// Codeword-in / info-out valid-ready channels of the SECDED decoder stage.
interface ecc_dec_stage_if #(
    parameter int CW_W   = 32,
    parameter int INFO_W = 26
);
    logic              in_valid;
    logic              in_ready;
    logic [CW_W-1:0]   data_in;
    logic [1:0]        mod;
    logic              out_valid;
    logic              out_ready;
    logic [INFO_W-1:0] data_out;
    logic [1:0]        status;
    logic [4:0]        err_pos;

    modport master (
        output in_valid, data_in, mod, out_ready,
        input  in_ready, out_valid, data_out, status, err_pos
    );

    modport slave (
        input  in_valid, data_in, mod, out_ready,
        output in_ready, out_valid, data_out, status, err_pos
    );
endinterface

// File: rtl/ecc_syndrome.sv
// Combinational syndrome of one codeword plus a one-hot vector marking the column
// that explains a single-bit error.
module ecc_syndrome
    import ecc_pkg::*;
(
    input  logic [CW_MAX-1:0] cw_i,
    input  logic [1:0]        mod_i,
    output logic [P_MAX-1:0]  syn_o,
    output logic [CW_MAX-1:0] match_o
);

    hmat_t             h;
    logic [CW_MAX-1:0] mask;
    logic [CW_MAX-1:0] cw_m;
    logic [P_MAX-2:0]  col;

    // Columns beyond n are zero in the Hamming rows, so they are masked out of the
    // search or they would alias the overall-parity column when sh = 0.
    always_comb begin
        h       = h_for_mode(mod_i);
        mask    = cw_mask(mod_i);
        cw_m    = cw_i & mask;
        syn_o   = '0;
        match_o = '0;
        col     = '0;
        for (int r = 0; r < P_MAX; r++) syn_o[r] = ^(cw_m & h[r]);
        for (int c = 0; c < CW_MAX; c++) begin
            for (int r = 1; r < P_MAX; r++) col[r - 1] = h[r][c];
            match_o[c] = syn_o[0] && mask[c] && (col == syn_o[P_MAX-1:1]);
        end
    end

endmodule

// File: rtl/ecc_dec_stage.sv
// SECDED receive stage: syndrome ahead of S1, single-bit correction ahead of S2,
// valid/ready flow control and saturating error statistics.
module ecc_dec_stage
    import ecc_pkg::*;
#(
    parameter int CW_W   = 32,
    parameter int INFO_W = 26,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    ecc_dec_stage_if.slave   bus,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt
);

    logic                s1_valid_q;
    logic [CW_MAX-1:0]   s1_cw_q;
    logic [CW_MAX-1:0]   s1_match_q;
    logic [1:0]          s1_mod_q;
    logic [P_MAX-1:0]    s1_syn_q;
    logic                s2_valid_q;
    logic [INFO_MAX-1:0] s2_data_q, s2_data_d;
    status_e             s2_status_q, s2_status_d;
    logic [4:0]          s2_pos_q, s2_pos_d;
    logic [CNT_W-1:0]    corr_cnt_q, uncorr_cnt_q;

    logic [CW_MAX-1:0]   cw_in;
    logic [CW_MAX-1:0]   match_in;
    logic [P_MAX-1:0]    syn_in;
    status_e             cls_in;
    logic                s1_adv, s2_adv, accept;

    assign cw_in  = CW_MAX'(bus.data_in[CW_W-1:0]);
    assign s2_adv = !s2_valid_q || bus.out_ready;
    assign s1_adv = !s1_valid_q || s2_adv;
    assign accept = bus.in_valid && s1_adv;
    assign cls_in = classify(bus.mod, syn_in, match_in);

    ecc_syndrome u_syndrome (
        .cw_i    (cw_in),
        .mod_i   (bus.mod),
        .syn_o   (syn_in),
        .match_o (match_in)
    );

    // The match vector is non-zero only for a correctable word, so XOR-ing it in is
    // the correction and leaves uncorrectable words raw.
    always_comb begin
        s2_status_d = classify(s1_mod_q, s1_syn_q, s1_match_q);
        s2_data_d   = info_of(s1_cw_q ^ s1_match_q, s1_mod_q);
        s2_pos_d    = (s2_status_d == STATUS_CORRECTED) ? onehot_idx(s1_match_q) : 5'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid_q   <= 1'b0;
            s1_cw_q      <= '0;
            s1_match_q   <= '0;
            s1_mod_q     <= '0;
            s1_syn_q     <= '0;
            s2_valid_q   <= 1'b0;
            s2_data_q    <= '0;
            s2_status_q  <= STATUS_CLEAN;
            s2_pos_q     <= '0;
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_cw_q    <= cw_in;
                    s1_match_q <= match_in;
                    s1_mod_q   <= bus.mod;
                    s1_syn_q   <= syn_in;
                end
            end
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_data_q   <= s2_data_d;
                    s2_status_q <= s2_status_d;
                    s2_pos_q    <= s2_pos_d;
                end
            end
            // A clear in the same cycle as a count event deliberately drops the event.
            if (cnt_clr) begin
                corr_cnt_q   <= '0;
                uncorr_cnt_q <= '0;
            end else begin
                if (accept && cls_in == STATUS_CORRECTED && corr_cnt_q != '1)
                    corr_cnt_q <= corr_cnt_q + CNT_W'(1);
                if (accept && cls_in == STATUS_UNCORR && uncorr_cnt_q != '1)
                    uncorr_cnt_q <= uncorr_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready  = s1_adv;
    assign bus.out_valid = s2_valid_q;
    assign bus.data_out  = INFO_W'(s2_data_q);
    assign bus.status    = s2_status_q;
    assign bus.err_pos   = s2_pos_q;
    assign corr_cnt      = corr_cnt_q;
    assign uncorr_cnt    = uncorr_cnt_q;

endmodule

// File: tb/tb_ecc_dec_stage.sv
// Directed bench for the SECDED decoder stage: hand-computed vectors, backpressure,
// counter corner cases, reset mid-stream and a single/double flip sweep per mode.
module tb_ecc_dec_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cnt_clr = 1'b0;
    logic [15:0] corr_cnt;
    logic [15:0] uncorr_cnt;
    int          checks = 0;
    int          errors = 0;

    ecc_dec_stage_if #(.CW_W(32), .INFO_W(26)) bus ();

    ecc_dec_stage #(.CW_W(32), .INFO_W(26), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .cnt_clr    (cnt_clr),
        .corr_cnt   (corr_cnt),
        .uncorr_cnt (uncorr_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Extended-Hamming encoder: info column b uses the b-th non-power-of-two value >= 3.
    function automatic logic [31:0] refEncode(input int p, input int n, input logic [25:0] info);
        logic [31:0] cw;
        int          v;
        cw = '0;
        v  = 3;
        for (int b = 0; b < n - p; b++) begin
            if ((v & (v - 1)) == 0) v++;
            if (info[b]) begin
                cw[p + b] = 1'b1;
                for (int r = 0; r < p - 1; r++) if (v[r]) cw[r] = ~cw[r];
            end
            v++;
        end
        cw[p - 1] = ^cw;
        return cw;
    endfunction

    function automatic logic [25:0] refInfo(input logic [31:0] cw, input int p, input int n);
        logic [31:0] t;
        t = (cw >> p) & ((32'd1 << (n - p)) - 32'd1);
        return t[25:0];
    endfunction

    // Offer one word at a negedge and return at the negedge after it was accepted.
    task automatic applyStimulus(input logic [1:0] m, input logic [31:0] d);
        int waitCycles;
        waitCycles   = 0;
        bus.in_valid = 1'b1;
        bus.mod      = m;
        bus.data_in  = d;
        while (!bus.in_ready && waitCycles < 20) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!bus.in_ready) checkOutput("accept_timeout", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic expectResult(input string tag, input logic [25:0] eData, input logic [1:0] eStat,
                                input logic [4:0] ePos);
        int waitCycles;
        waitCycles = 0;
        while (!bus.out_valid && waitCycles < 10) begin
            @(negedge clk);
            waitCycles++;
        end
        checkOutput({tag, "_valid"},  32'(bus.out_valid), 32'd1);
        checkOutput({tag, "_data"},   32'(bus.data_out),  32'(eData));
        checkOutput({tag, "_status"}, 32'(bus.status),    32'(eStat));
        checkOutput({tag, "_pos"},    32'(bus.err_pos),   32'(ePos));
    endtask

    task automatic runWord(input string tag, input logic [1:0] m, input logic [31:0] d,
                           input logic [25:0] eData, input logic [1:0] eStat, input logic [4:0] ePos);
        applyStimulus(m, d);
        expectResult(tag, eData, eStat, ePos);
        @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.data_in   = '0;
        bus.mod       = 2'b00;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_data",      32'(bus.data_out),  32'd0);
        checkOutput("rst_status",    32'(bus.status),    32'd0);
        checkOutput("rst_pos",       32'(bus.err_pos),   32'd0);
        checkOutput("rst_corr",      32'(corr_cnt),      32'd0);
        checkOutput("rst_uncorr",    32'(uncorr_cnt),    32'd0);
        checkOutput("rst_in_ready",  32'(bus.in_ready),  32'd1);

        $display("[TB] clean word and latency");
        bus.in_valid = 1'b1;
        bus.mod      = 2'b00;
        bus.data_in  = 32'h0000_00AA;
        checkOutput("lat_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        checkOutput("lat_t1_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        checkOutput("lat_t2_valid", 32'(bus.out_valid), 32'd1);
        expectResult("clean_aa", 26'h00A, 2'b00, 5'd0);
        @(negedge clk);

        $display("[TB] directed single and double errors");
        runWord("err_b6",    2'b00, 32'h0000_00EA, 26'h00A, 2'b01, 5'd6);
        checkOutput("err_b6_corr", 32'(corr_cnt), 32'd1);
        runWord("err_b3",    2'b00, 32'h0000_00A2, 26'h00A, 2'b01, 5'd3);
        runWord("dbl_eb",    2'b00, 32'h0000_00EB, 26'h00E, 2'b10, 5'd0);
        checkOutput("dbl_eb_uncorr", 32'(uncorr_cnt), 32'd1);
        runWord("hi_ignored", 2'b00, 32'hFFFF_FFAA, 26'h00A, 2'b00, 5'd0);
        runWord("m1_clean",  2'b01, 32'h0000_0033, 26'h001, 2'b00, 5'd0);
        runWord("m1_b10",    2'b01, 32'h0000_0433, 26'h001, 2'b01, 5'd10);
        runWord("m2_clean",  2'b10, 32'h0000_0063, 26'h001, 2'b00, 5'd0);
        runWord("m2_b31",    2'b10, 32'h8000_0063, 26'h001, 2'b01, 5'd31);
        runWord("m2_dbl",    2'b10, 32'h8000_0062, 26'h2000001, 2'b10, 5'd0);
        checkOutput("dir_corr",   32'(corr_cnt),   32'd4);
        checkOutput("dir_uncorr", 32'(uncorr_cnt), 32'd2);

        $display("[TB] invalid mode");
        runWord("inv_mode", 2'b11, 32'h0000_00EA, 26'h000, 2'b11, 5'd0);
        checkOutput("inv_corr",   32'(corr_cnt),   32'd4);
        checkOutput("inv_uncorr", 32'(uncorr_cnt), 32'd2);

        $display("[TB] backpressure");
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.mod       = 2'b00;
        bus.data_in   = 32'h0000_00AA;
        checkOutput("bp_rdy0", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.data_in = 32'h0000_00EA;
        checkOutput("bp_rdy1", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.mod     = 2'b01;
        bus.data_in = 32'h0000_0433;
        checkOutput("bp_rdy_drop", 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            expectResult("bp_hold", 26'h00A, 2'b00, 5'd0);
            checkOutput("bp_hold_rdy", 32'(bus.in_ready), 32'd0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.mod     = 2'b00;
        bus.data_in = 32'h0000_00EB;
        expectResult("bp_w1", 26'h00A, 2'b01, 5'd6);
        @(negedge clk);
        bus.in_valid = 1'b0;
        expectResult("bp_w2", 26'h001, 2'b01, 5'd10);
        @(negedge clk);
        expectResult("bp_w3", 26'h00E, 2'b10, 5'd0);
        @(negedge clk);
        checkOutput("bp_drained", 32'(bus.out_valid), 32'd0);
        checkOutput("bp_corr",    32'(corr_cnt),      32'd6);
        checkOutput("bp_uncorr",  32'(uncorr_cnt),    32'd3);

        $display("[TB] clear with simultaneous error");
        cnt_clr = 1'b1;
        applyStimulus(2'b00, 32'h0000_00EA);
        cnt_clr = 1'b0;
        checkOutput("clr_corr",   32'(corr_cnt),   32'd0);
        checkOutput("clr_uncorr", 32'(uncorr_cnt), 32'd0);
        expectResult("clr_word", 26'h00A, 2'b01, 5'd6);
        @(negedge clk);

        $display("[TB] single/double flip sweep");
        for (int m = 0; m < 3; m++) begin
            int          p;
            int          n;
            logic [25:0] info;
            logic [31:0] cw;
            logic [31:0] bad;
            p    = (m == 0) ? 4 : (m == 1) ? 5 : 6;
            n    = (m == 0) ? 8 : (m == 1) ? 16 : 32;
            info = (m == 0) ? 26'h5 : (m == 1) ? 26'h5A3 : 26'h2B4C6D1;
            cw   = refEncode(p, n, info);
            runWord($sformatf("sw_clean_m%0d", m), 2'(m), cw, info, 2'b00, 5'd0);
            for (int i = 0; i < n; i++) begin
                runWord($sformatf("sw1_m%0d_b%0d", m, i), 2'(m), cw ^ (32'd1 << i), info, 2'b01, 5'(i));
            end
            for (int i = 0; i < n; i++) begin
                for (int j = i + 1; j < n; j++) begin
                    bad = cw ^ (32'd1 << i) ^ (32'd1 << j);
                    runWord($sformatf("sw2_m%0d_b%0d_%0d", m, i, j), 2'(m), bad, refInfo(bad, p, n), 2'b10, 5'd0);
                end
            end
        end
        checkOutput("sweep_corr",   32'(corr_cnt),   32'd56);
        checkOutput("sweep_uncorr", 32'(uncorr_cnt), 32'd644);

        $display("[TB] counter saturation");
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr       = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.mod       = 2'b00;
        bus.data_in   = 32'h0000_00EA;
        repeat (65534) @(negedge clk);
        checkOutput("sat_below", 32'(corr_cnt), 32'h0000_FFFE);
        @(negedge clk);
        checkOutput("sat_top", 32'(corr_cnt), 32'h0000_FFFF);
        @(negedge clk);
        checkOutput("sat_hold",   32'(corr_cnt),   32'h0000_FFFF);
        checkOutput("sat_uncorr", 32'(uncorr_cnt), 32'd0);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] reset mid-stream");
        bus.out_ready = 1'b0;
        applyStimulus(2'b00, 32'h0000_00EB);
        applyStimulus(2'b00, 32'h0000_00A2);
        checkOutput("mr_inflight", 32'(bus.out_valid), 32'd1);
        checkOutput("mr_rdy_low",  32'(bus.in_ready),  32'd0);
        checkOutput("mr_uncorr_pre", 32'(uncorr_cnt),  32'd1);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("mr_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("mr_corr",      32'(corr_cnt),      32'd0);
        checkOutput("mr_uncorr",    32'(uncorr_cnt),    32'd0);
        checkOutput("mr_in_ready",  32'(bus.in_ready),  32'd1);
        checkOutput("mr_status",    32'(bus.status),    32'd0);
        rst           = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("mr_no_stale", 32'(bus.out_valid), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
